// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   LSU_ADDR_W : default number of decoded byte-address bits (16 KB window)
//   F3_*       : RV32I load/store funct3 encodings
//   lsu_state_t: LSU control states
//   f3_illegal : funct3 values that have no load/store meaning
package lsu_pkg;

    localparam int LSU_ADDR_W = 14;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } lsu_state_t;

    // Stores only have SB/SH/SW; loads have no 011/110/111.
    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        if (store) begin
            return f3[2] || (f3[1:0] == 2'b11);
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request / memory / response bundle of the load/store unit.
//   req_*  : one LOAD/STORE per req_valid && req_ready handshake
//   mem_*  : word-wide memory command port with byte strobes, read data return
//   resp_* : one-cycle completion pulse with rd, extended data and error flag
// slave  = the LSU's view, master = the surrounding pipeline/memory's view.
interface lsu_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              resp_valid;
    logic [4:0]        resp_rd;
    logic [31:0]       resp_data;
    logic              resp_err;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready,
        output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output resp_valid, resp_rd, resp_data, resp_err
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready,
        input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  resp_valid, resp_rd, resp_data, resp_err
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
//   funct3     in  : access size/sign
//   addr_lo    in  : byte offset within the word
//   wdata      in  : store data (rs2)
//   rdata      in  : word read from memory
//   wstrb      out : byte-lane write enables for a store
//   wdata_lane out : store data replicated across lanes
//   rdata_ext  out : load data shifted down and sign/zero-extended
//   misaligned out : half not on 2-byte or word not on 4-byte boundary
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] shifted;

    always_comb begin
        wstrb      = '0;
        wdata_lane = '0;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                wstrb      = '1;
                wdata_lane = wdata;
                misaligned = |addr_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata_ext = shifted;
            F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
            F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit between execute and writeback.
//   clk    : rising-edge clock
//   resetn : asynchronous reset, active HIGH despite the name
//   bus    : lsu_if.slave -- request handshake, memory command port, response pulse
// One access in flight: IDLE accepts, ISSUE holds the memory command until
// mem_ready, WAIT collects load data, RESP pulses the result. Illegal or
// misaligned requests skip memory and go straight to RESP with resp_err.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic clk,
    input  logic resetn,
    lsu_if.slave bus
);

    lsu_state_t state, state_nxt;

    logic        store_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;

    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_mis;
    logic        req_illegal;

    logic              mem_we_q;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [3:0]        mem_wstrb_q;
    logic [31:0]       mem_wdata_q;
    logic              resp_err_q;
    logic [4:0]        resp_rd_q;
    logic [31:0]       resp_data_q;

    logic unused_addr_hi;

    // Address bits above the decoded window alias.
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

    // One aligner serves both directions: in IDLE it sees the incoming request
    // (store lanes, legality); afterwards it sees the latched size/offset so
    // the read word can be extracted in WAIT.
    assign al_f3  = (state == IDLE) ? bus.req_funct3   : f3_q;
    assign al_off = (state == IDLE) ? bus.req_addr[1:0] : off_q;

    lsu_align u_align (
        .funct3     (al_f3),
        .addr_lo    (al_off),
        .wdata      (bus.req_wdata),
        .rdata      (bus.mem_rdata),
        .wstrb      (al_wstrb),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_mis)
    );

    assign req_illegal = al_mis || f3_illegal(bus.req_store, bus.req_funct3);

    // State register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = req_illegal ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    state_nxt = store_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE:    bus.req_ready  = 1'b1;
            ISSUE:   bus.mem_valid  = 1'b1;
            RESP:    bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch, memory command and response registers
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            store_q     <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            resp_err_q  <= 1'b0;
            resp_rd_q   <= '0;
            resp_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        store_q <= bus.req_store;
                        f3_q    <= bus.req_funct3;
                        off_q   <= bus.req_addr[1:0];
                        rd_q    <= bus.req_rd;
                        if (req_illegal) begin
                            resp_err_q  <= 1'b1;
                            resp_data_q <= '0;
                            resp_rd_q   <= bus.req_store ? 5'd0 : bus.req_rd;
                        end else begin
                            mem_we_q    <= bus.req_store;
                            mem_addr_q  <= bus.req_addr[ADDR_W-1:2];
                            mem_wstrb_q <= bus.req_store ? al_wstrb : 4'b0000;
                            mem_wdata_q <= bus.req_store ? al_wdata : 32'h0;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready && store_q) begin
                        resp_err_q  <= 1'b0;
                        resp_data_q <= '0;
                        resp_rd_q   <= '0;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        resp_err_q  <= 1'b0;
                        resp_data_q <= al_rdata;
                        resp_rd_q   <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.resp_err  = resp_err_q;
    assign bus.resp_rd   = resp_rd_q;
    assign bus.resp_data = resp_data_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_if #(.ADDR_W(14)) bus ();
    lsu #(.ADDR_W(14)) dut (.clk(clk), .resetn(rst), .bus(bus));

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } cmd_t;

    resp_t       expq[$];
    cmd_t        cmdq[$];
    logic [7:0]  ref_mem [0:16383];
    logic [31:0] mem_word [0:4095];

    int          stall_mode = -1;
    int          rv_mode = -1;
    bit          noise = 1'b1;
    bit          force_stray = 1'b0;
    int          resp_cnt = 0;
    int          last_resp_cyc = 0;
    logic [31:0] last_resp_data = '0;
    logic [4:0]  last_resp_rd = '0;
    logic        last_resp_err = 1'b0;
    int          acc_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_illegal(input bit st, input logic [2:0] f3, input logic [1:0] lo);
        if (st && f3 > 3'd2) return 1'b1;
        if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        if (f3[1:0] == 2'd1 && lo[0]) return 1'b1;
        if (f3[1:0] == 2'd2 && lo != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: byte-addressed memory, expected command and response per access.
    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        resp_t       r;
        cmd_t        c;
        int          size;
        int          base;
        logic [31:0] v;
        base = int'(a[13:0]);
        size = 1 << f3[1:0];
        if (is_illegal(st, f3, a[1:0])) begin
            r = '{rd: (st ? 5'd0 : rd), data: 32'd0, err: 1'b1};
            expq.push_back(r);
            return;
        end
        c.we    = st;
        c.addr  = a[13:2];
        c.wstrb = '0;
        c.wdata = '0;
        if (st) begin
            for (int i = 0; i < size; i++) begin
                ref_mem[base + i] = wd[8*i +: 8];
                c.wstrb[base % 4 + i] = 1'b1;
            end
            for (int l = 0; l < 4; l++) c.wdata[8*l +: 8] = wd[8*(l % size) +: 8];
            r = '{rd: 5'd0, data: 32'd0, err: 1'b0};
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[base + i];
            if (!f3[2] && size < 4 && v[8*size - 1]) begin
                for (int i = 8 * size; i < 32; i++) v[i] = 1'b1;
            end
            r = '{rd: rd, data: v, err: 1'b0};
        end
        cmdq.push_back(c);
        expq.push_back(r);
    endtask

    task automatic check_cmd(input cmd_t c, input string tag);
        chk({tag, "_valid"}, 32'(bus.mem_valid), 32'd1);
        chk({tag, "_we"},    32'(bus.mem_we),    32'(c.we));
        chk({tag, "_addr"},  32'(bus.mem_addr),  32'(c.addr));
        chk({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'(c.wstrb));
        if (c.we) chk({tag, "_wdata"}, bus.mem_wdata, c.wdata);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
        chk({tag, "_mem_valid"},  32'(bus.mem_valid),  32'd0);
        chk({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
        chk({tag, "_mem_wstrb"},  32'(bus.mem_wstrb),  32'd0);
        chk({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
        chk({tag, "_mem_wdata"},  bus.mem_wdata,       32'd0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_err"},   32'(bus.resp_err),   32'd0);
        chk({tag, "_resp_rd"},    32'(bus.resp_rd),    32'd0);
        chk({tag, "_resp_data"},  bus.resp_data,       32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input bit hold);
        int guard;
        guard = 0;
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        while (bus.req_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: req_ready=%b expected 1", bus.req_ready);
                bus.req_valid = 1'b0;
                return;
            end
        end
        acc_cyc = cyc;
        model(st, f3, a, wd, rd);
        @(negedge clk);
        if (!hold) begin
            bus.req_valid  = 1'b0;
            bus.req_store  = 1'($urandom_range(1));
            bus.req_funct3 = 3'($urandom_range(7));
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            bus.req_rd     = 5'($urandom_range(31));
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (expq.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: %0d responses outstanding expected 0", expq.size());
                expq.delete();
                cmdq.delete();
                return;
            end
        end
        @(negedge clk);
    endtask

    // Memory responder: random/fixed mem_ready stalls, rvalid delay, noise when idle.
    initial begin : responder
        int          phase;
        int          cnt;
        cmd_t        cur;
        logic [31:0] rdat;
        phase = 0;
        cnt = 0;
        rdat = '0;
        cur = '{we: 1'b0, addr: 12'd0, wstrb: 4'd0, wdata: 32'd0};
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (rst) begin
                phase = 0;
            end else if (phase == 2) begin
                if (cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rdat;
                    phase = 0;
                end else begin
                    cnt--;
                end
            end else if (phase == 1 || bus.mem_valid === 1'b1) begin
                if (phase == 0) begin
                    if (cmdq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_mem_cmd: got mem_valid=1 expected no command");
                        cur = '{we: bus.mem_we, addr: bus.mem_addr, wstrb: bus.mem_wstrb, wdata: bus.mem_wdata};
                    end else begin
                        cur = cmdq.pop_front();
                    end
                    check_cmd(cur, "mem_cmd");
                    cnt = (stall_mode >= 0) ? stall_mode : int'($urandom_range(3));
                    phase = 1;
                end else begin
                    check_cmd(cur, "mem_hold");
                    cnt--;
                end
                if (cnt == 0) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_we) begin
                        for (int l = 0; l < 4; l++) begin
                            if (bus.mem_wstrb[l]) mem_word[bus.mem_addr][8*l +: 8] = bus.mem_wdata[8*l +: 8];
                        end
                        phase = 0;
                    end else begin
                        rdat  = mem_word[bus.mem_addr];
                        cnt   = (rv_mode >= 0) ? rv_mode : int'($urandom_range(3));
                        phase = 2;
                    end
                end
            end else if (noise || force_stray) begin
                bus.mem_ready  = force_stray ? 1'b1 : 1'($urandom_range(1));
                bus.mem_rvalid = force_stray ? 1'b1 : 1'($urandom_range(1));
                bus.mem_rdata  = $urandom;
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.resp_valid === 1'b1) begin
                resp_cnt++;
                last_resp_cyc  = cyc;
                last_resp_data = bus.resp_data;
                last_resp_rd   = bus.resp_rd;
                last_resp_err  = bus.resp_err;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("resp_rd",   32'(bus.resp_rd),  32'(e.rd));
                    chk("resp_data", bus.resp_data,     e.data);
                    chk("resp_err",  32'(bus.resp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation still running expected completion");
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        logic [31:0] w;
        int          r1;
        int          n0;
        int          nv;
        bit          ok;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_rd     = '0;
        for (int i = 0; i < 4096; i++) begin
            w = (i == 1) ? 32'h8001_1234 : $urandom;
            mem_word[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end

        @(negedge clk);
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // SB 0xA5 @3, best case
        stall_mode = 0;
        issue(1'b1, F3_B, 32'h0000_0003, 32'h1234_56A5, 5'd7, 1'b0);
        chk("sb_mem_valid", 32'(bus.mem_valid), 32'd1);
        chk("sb_mem_we",    32'(bus.mem_we),    32'd1);
        chk("sb_wstrb",     32'(bus.mem_wstrb), 32'h8);
        chk("sb_wdata",     bus.mem_wdata,      32'hA5A5_A5A5);
        wait_drain();
        chk("sb_latency", 32'(last_resp_cyc - acc_cyc), 32'd2);
        chk("sb_err",     32'(last_resp_err),           32'd0);

        // LW misaligned
        issue(1'b0, F3_W, 32'h0000_0002, 32'h0, 5'd3, 1'b0);
        chk("lw_mis_no_mem", 32'(bus.mem_valid), 32'd0);
        wait_drain();
        chk("lw_mis_latency", 32'(last_resp_cyc - acc_cyc), 32'd1);
        chk("lw_mis_err",     32'(last_resp_err),           32'd1);
        chk("lw_mis_data",    last_resp_data,               32'd0);

        // SW with 3 stall cycles
        stall_mode = 3;
        issue(1'b1, F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 1'b0);
        nv = 0;
        ok = 1'b1;
        while (bus.mem_valid === 1'b1 && nv < 20) begin
            nv++;
            if (bus.req_ready !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("sw_stall_valid_cycles", 32'(nv), 32'd4);
        chk("sw_stall_ready_low",    32'(ok), 32'd1);
        stall_mode = -1;
        wait_drain();

        // Back-to-back LW then SW with req_valid held
        issue(1'b0, F3_W, 32'h0000_0004, 32'h0, 5'd12, 1'b1);
        issue(1'b1, F3_W, 32'h0000_0008, 32'hCAFE_F00D, 5'd13, 1'b0);
        r1 = last_resp_cyc;
        chk("b2b_accept", 32'(acc_cyc), 32'(r1 + 1));
        wait_drain();

        // LH / LHU @6 (aliased upper bits)
        issue(1'b0, F3_H, 32'h8000_0006, $urandom, 5'd9, 1'b0);
        wait_drain();
        chk("lh_data", last_resp_data, 32'hFFFF_8001);
        chk("lh_rd",   32'(last_resp_rd), 32'd9);
        issue(1'b0, F3_HU, 32'h8000_0006, $urandom, 5'd10, 1'b0);
        wait_drain();
        chk("lhu_data", last_resp_data, 32'h0000_8001);

        // LB @1, reset while waiting for read data
        stall_mode = 0;
        rv_mode = 30;
        issue(1'b0, F3_B, 32'h0000_0001, 32'h0, 5'd5, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_wait");
        expq.delete();
        cmdq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        force_stray = 1'b1;
        n0 = resp_cnt;
        repeat (3) @(negedge clk);
        force_stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_no_resp", 32'(resp_cnt - n0), 32'd0);
        chk("post_reset_ready",   32'(bus.req_ready),  32'd1);
        stall_mode = -1;
        rv_mode = -1;

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] a;
            int          sz;
            st = 1'($urandom_range(1));
            if ($urandom_range(4) == 0) begin
                f3 = 3'($urandom_range(7));
            end else if (st) begin
                f3 = 3'($urandom_range(2));
            end else begin
                case ($urandom_range(4))
                    0:       f3 = F3_B;
                    1:       f3 = F3_H;
                    2:       f3 = F3_W;
                    3:       f3 = F3_BU;
                    default: f3 = F3_HU;
                endcase
            end
            a = ($urandom & 32'hF000_0000) | 32'($urandom_range(255));
            sz = 1 << f3[1:0];
            if ($urandom_range(3) != 0) a = a & ~(32'(sz) - 32'd1);
            issue(st, f3, a, $urandom, 5'($urandom_range(31)), 1'b0);
            repeat ($urandom_range(2)) @(negedge clk);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
